// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: memory-op encodings, access-size helpers and
// the memory-stage FSM state type.
package pipe_pkg;

    // Memory-op codes carried from the execute stage.
    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LD   = 4'd4,
        MEM_LBU  = 4'd5,
        MEM_LHU  = 4'd6,
        MEM_LWU  = 4'd7,
        MEM_SB   = 4'd8,
        MEM_SH   = 4'd9,
        MEM_SW   = 4'd10,
        MEM_SD   = 4'd11
    } mem_op_e;

    // Memory-stage FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } regm_state_e;

    // Access size as log2(bytes): 0=byte, 1=half, 2=word, 3=doubleword.
    function automatic logic [1:0] memSizeLog2(input mem_op_e op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: memSizeLog2 = 2'd0;
            MEM_LH, MEM_LHU, MEM_SH: memSizeLog2 = 2'd1;
            MEM_LW, MEM_LWU, MEM_SW: memSizeLog2 = 2'd2;
            default:                 memSizeLog2 = 2'd3;
        endcase
    endfunction

    function automatic logic isStore(input mem_op_e op);
        isStore = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW) || (op == MEM_SD);
    endfunction

    // Byte strobe pattern for lane 0 of an access of the given size.
    function automatic logic [7:0] baseStrobe(input logic [1:0] sizeLog2);
        case (sizeLog2)
            2'd0:    baseStrobe = 8'h01;
            2'd1:    baseStrobe = 8'h03;
            2'd2:    baseStrobe = 8'h0F;
            default: baseStrobe = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner: moves the addressed bytes of a returned
// doubleword down to bit 0 and sign- or zero-extends them.
module mem_load_align
    import pipe_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [2:0]       addrLo,
    input  mem_op_e          memOp,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] shifted;

    // Shift the addressed byte lane down to bit 0.
    always_comb begin
        shifted = rdata >> {addrLo, 3'b000};
    end

    // Extend according to the load type; LD passes the doubleword through.
    always_comb begin
        case (memOp)
            MEM_LB:  result = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            MEM_LH:  result = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            MEM_LW:  result = {{(WIDTH-32){shifted[31]}}, shifted[31:0]};
            MEM_LBU: result = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            MEM_LHU: result = {{(WIDTH-16){1'b0}}, shifted[15:0]};
            MEM_LWU: result = {{(WIDTH-32){1'b0}}, shifted[31:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/regm.sv
// Memory-access pipeline stage. Holds one execute-stage result, performs at
// most one data-memory request for it, and hands the write-back payload on.
//
// Handshake: a stage-to-stage transfer happens on a rising edge where the
// upstream valid and the downstream allow_in are both 1; the memory request
// transfers on an edge where dmem_req_valid and dmem_req_ready are both 1, and
// request fields stay stable while valid waits for ready.
module regm
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int INSTR_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  regE_to_regM_valid,
    output logic                  regM_allow_in,
    input  logic                  regW_allow_in,
    output logic                  regM_to_regW_valid,
    input  logic [WIDTH-1:0]      e_pc,
    input  logic [INSTR_SIZE-1:0] e_instr,
    input  logic [WIDTH-1:0]      e_alu_result,
    input  logic [WIDTH-1:0]      e_store_data,
    input  logic [3:0]            e_mem_op,
    input  logic [4:0]            e_rd,
    input  logic                  e_rd_wen,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_req_wen,
    output logic [WIDTH-1:0]      dmem_req_addr,
    output logic [WIDTH-1:0]      dmem_req_wdata,
    output logic [7:0]            dmem_req_wstrb,
    input  logic                  dmem_resp_valid,
    input  logic [WIDTH-1:0]      dmem_resp_rdata,
    output logic [WIDTH-1:0]      m_pc,
    output logic [INSTR_SIZE-1:0] m_instr,
    output logic [4:0]            m_rd,
    output logic                  m_rd_wen,
    output logic [WIDTH-1:0]      m_wb_data,
    output regm_state_e           dbg_state
);

    regm_state_e      state;
    regm_state_e      nextState;
    logic             regM_valid;
    logic             regM_ready_go;
    logic             accept;
    logic             wHandoff;
    logic [WIDTH-1:0] aluQ;
    logic [WIDTH-1:0] storeQ;
    mem_op_e          memOpQ;
    logic [1:0]       sizeLog2;
    logic [2:0]       laneOff;
    logic [WIDTH-1:0] loadResult;

    assign accept             = regE_to_regM_valid && regM_allow_in;
    assign regM_allow_in      = !regM_valid || (regM_ready_go && regW_allow_in);
    assign regM_to_regW_valid = regM_valid && regM_ready_go;
    assign wHandoff           = regM_to_regW_valid && regW_allow_in;
    assign dbg_state          = state;

    // Stage occupancy: refilled (or emptied) whenever the stage can accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regM_valid <= 1'b0;
        end else if (regM_allow_in) begin
            regM_valid <= regE_to_regM_valid;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM next state; a new accept overrides every other transition.
    always_comb begin
        nextState = state;
        if (accept) begin
            nextState = (e_mem_op == MEM_NONE) ? S_IDLE : S_REQ;
        end else begin
            case (state)
                S_IDLE: nextState = S_IDLE;
                S_REQ: begin
                    if (dmem_req_ready) begin
                        nextState = isStore(memOpQ) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_resp_valid) begin
                        nextState = S_DONE;
                    end
                end
                S_DONE: begin
                    if (wHandoff) begin
                        nextState = S_IDLE;
                    end
                end
                default: nextState = S_IDLE;
            endcase
        end
    end

    // FSM outputs: request strobe and stage completion.
    always_comb begin
        dmem_req_valid = 1'b0;
        regM_ready_go  = 1'b0;
        case (state)
            S_IDLE:  regM_ready_go  = 1'b1;
            S_REQ:   dmem_req_valid = 1'b1;
            S_WAIT:  regM_ready_go  = 1'b0;
            S_DONE:  regM_ready_go  = 1'b1;
            default: regM_ready_go  = 1'b0;
        endcase
    end

    // Payload registers load only on accept and otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc     <= '0;
            m_instr  <= '0;
            m_rd     <= '0;
            m_rd_wen <= 1'b0;
            aluQ     <= '0;
            storeQ   <= '0;
            memOpQ   <= MEM_NONE;
        end else if (accept) begin
            m_pc     <= e_pc;
            m_instr  <= e_instr;
            m_rd     <= e_rd;
            m_rd_wen <= e_rd_wen;
            aluQ     <= e_alu_result;
            storeQ   <= e_store_data;
            memOpQ   <= mem_op_e'(e_mem_op);
        end
    end

    // Write-back data starts as the ALU result and is replaced by the
    // aligned load data when the response arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wb_data <= '0;
        end else if (accept) begin
            m_wb_data <= e_alu_result;
        end else if ((state == S_WAIT) && dmem_resp_valid) begin
            m_wb_data <= loadResult;
        end
    end

    // Store encoding: offset bits below the access size are ignored, data is
    // replicated so every lane the strobe can select carries it.
    always_comb begin
        sizeLog2       = memSizeLog2(memOpQ);
        laneOff        = aluQ[2:0] & (3'b111 << sizeLog2);
        dmem_req_addr  = {aluQ[WIDTH-1:3], 3'b000};
        dmem_req_wen   = isStore(memOpQ);
        dmem_req_wstrb = isStore(memOpQ) ? (baseStrobe(sizeLog2) << laneOff) : 8'h00;
        case (sizeLog2)
            2'd0:    dmem_req_wdata = {8{storeQ[7:0]}};
            2'd1:    dmem_req_wdata = {4{storeQ[15:0]}};
            2'd2:    dmem_req_wdata = {2{storeQ[31:0]}};
            default: dmem_req_wdata = storeQ;
        endcase
    end

    mem_load_align #(
        .WIDTH(WIDTH)
    ) u_align (
        .rdata  (dmem_resp_rdata),
        .addrLo (aluQ[2:0]),
        .memOp  (memOpQ),
        .result (loadResult)
    );

endmodule

// File: doc/regm.md
Name: regM

Overview:
- Pipeline stage 3, memory access. Sits directly downstream of the execute-stage register and upstream of write-back.
- Accepts one execute-stage result per valid/allow_in handshake.
- For loads and stores, issues a single data-memory request and waits for its completion. For loads, aligns and extends the returned data.
- Presents the write-back payload to the W stage under the same valid/allow_in discipline used by every other pipeline stage.

Parameters:
- WIDTH, 64, datapath and address width.
- INSTR_SIZE, 32, instruction width, carried for commit/trace.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 resets immediately, deassertion synchronous to clk externally.
- regE_to_regM_valid  in  1  E stage offers an instruction.
- regM_allow_in  out  1  M can accept this cycle.
- regW_allow_in  in  1  W stage can accept.
- regM_to_regW_valid  out  1  M offers a finished instruction.
- e_pc  in  WIDTH  PC of the offered instruction.
- e_instr  in  INSTR_SIZE  instruction word.
- e_alu_result  in  WIDTH  ALU result / effective address.
- e_store_data  in  WIDTH  rs2 value for stores.
- e_mem_op  in  4  memory-op code (package encoding).
- e_rd  in  5  destination register.
- e_rd_wen  in  1  register write enable.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_req_wen  out  1  1 means store.
- dmem_req_addr  out  WIDTH  8-byte-aligned address (addr[2:0]=0).
- dmem_req_wdata  out  WIDTH  store data lane-replicated.
- dmem_req_wstrb  out  8  byte strobes.
- dmem_resp_valid  in  1  load data valid.
- dmem_resp_rdata  in  WIDTH  load data (full doubleword).
- m_pc, m_instr, m_rd, m_rd_wen  out  as above  registered copies to W.
- m_wb_data  out  WIDTH  load result or ALU result.

Behaviour:
- Handshake:
  - regM_allow_in = !regM_valid || (regM_ready_go && regW_allow_in).
  - regM_to_regW_valid = regM_valid && regM_ready_go.
  - When regM_allow_in, regM_valid <= regE_to_regM_valid.
  - Payload registers load only when regE_to_regM_valid && regM_allow_in; otherwise they hold.
- FSM states: IDLE, REQ, WAIT, DONE. Reset state IDLE.
- On accept:
  - e_mem_op==MEM_NONE: state goes to IDLE.
  - Otherwise: state goes to REQ.
  - Accept takes priority over all other transitions. Back-to-back memory ops go DONE->REQ without passing through IDLE.
- IDLE: ready_go = 1. dmem_req_valid = 0.
- REQ:
  - dmem_req_valid = 1; address, wdata, wstrb and wen are stable until the request handshake completes.
  - On dmem_req_ready: a store goes to DONE, a load goes to WAIT.
  - ready_go = 0.
- WAIT:
  - On dmem_resp_valid, capture the aligned load result into m_wb_data and go to DONE.
  - ready_go = 0.
  - dmem_resp_valid is ignored in every state except WAIT.
- DONE:
  - ready_go = 1.
  - If W accepts and there is no new accept, state goes to IDLE.
- Earliest completion: a load completes no earlier than 2 cycles after accept.
- Store encoding:
  - Size 1/2/4/8 bytes → base strobe 0x01/0x03/0x0F/0xFF, shifted left by addr[2:0].
  - wdata = store data replicated across lanes.
  - Address low bits below the access size are treated as zero; misalignment is not detected.
- Load alignment:
  - Shift rdata right by addr[2:0]*8.
  - Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU.
  - LD passes the doubleword through unchanged.
- m_wb_data:
  - For a load, m_wb_data is the aligned load result.
  - For any other instruction it is e_alu_result.
  - It is registered, so it is stable while the instruction is held.
- Reset values:
  - regM_valid=0, state=IDLE, dmem_req_valid=0, regM_to_regW_valid=0.
  - regM_allow_in=1; all payload outputs = 0.
- Reset mid-transaction: state is dropped with no completion. Any late response is ignored (state is IDLE).
- Stall: when regW_allow_in=0 in DONE/IDLE with a valid instruction, the instruction and m_wb_data hold and regM_allow_in=0.

Decomposition:
- Shared package pipe_pkg:
  - MEM_NONE/LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD encodings.
  - Size decode function.
  - regM FSM state enum.
- Sub-module mem_load_align: combinational, (rdata, addr[2:0], mem_op) → WIDTH result.

Test Plan:
- ALU op, W always ready: accept addi result 0x1234 → regM_to_regW_valid next cycle, m_wb_data=0x1234, no dmem request.
- LB at addr 0x1003, resp_rdata 0x0000_0000_8000_0000 → m_wb_data=0xFFFF_FFFF_FFFF_FF80 (sign-extend byte 3).
- SH at 0x2006, data 0xABCD, req_ready delayed 3 cycles:
  - wstrb=0xC0, wdata lanes hold 0xABCD, request stable all 3 cycles.
  - DONE on handshake.
- Load then back-to-back SW with regW_allow_in=0 for 2 cycles: regM_allow_in=0 while held, no second request until handoff; then REQ.
- rst=0 asserted in WAIT, followed by a late dmem_resp_valid: outputs reset immediately, response ignored, regM_valid stays 0.
- LWU at 0x3004, rdata 0xF000_0001_xxxx_xxxx → m_wb_data=0x0000_0000_F000_0001.
